// File: rtl/bch_serial_encode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bch_serial_encode_pkg                                        |
// | Description : Shared BCH helpers: field size from N, GF(2^m) arithmetic,  |
// |               minimal polynomials and generator-polynomial construction.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bch_serial_encode_pkg;

    localparam int MAX_M  = 6;
    localparam int POLY_W = 64;

    typedef logic [POLY_W-1:0] poly_t;

    // Field degree m such that N = 2^m - 1; 0 when N is not of that form.
    function automatic int n2m(input int n);
        int m;
        m = 0;
        for (int i = 1; i <= MAX_M; i++) begin
            if (((1 << i) - 1) == n) m = i;
        end
        return m;
    endfunction

    // Primitive polynomial used to build GF(2^m); bit m is the x^m term.
    function automatic int bch_prim_poly(input int m);
        int p;
        case (m)
            2:       p = 'h7;
            3:       p = 'hB;
            4:       p = 'h13;
            5:       p = 'h25;
            6:       p = 'h43;
            default: p = 0;
        endcase
        return p;
    endfunction

    function automatic int gf_mul(input int a, input int b, input int m, input int prim);
        int r;
        int x;
        r = 0;
        x = a;
        for (int k = 0; k < MAX_M; k++) begin
            if (k < m && ((b >> k) & 1) == 1) r = r ^ x;
            x = x << 1;
            if (((x >> m) & 1) == 1) x = x ^ prim;
        end
        return r;
    endfunction

    function automatic int gf_pow(input int e, input int m, input int prim);
        int a;
        a = 1;
        for (int k = 0; k < POLY_W; k++) begin
            if (k < e) a = gf_mul(a, 2, m, prim);
        end
        return a;
    endfunction

    // Minimal polynomial of alpha^i: product of (x + alpha^j) over the
    // cyclotomic coset of i. Coefficients collapse to GF(2).
    function automatic poly_t bch_min_poly(input int i, input int m);
        int    n;
        int    prim;
        int    c [0:MAX_M];
        int    j;
        int    root;
        bit    done;
        poly_t p;
        n    = (1 << m) - 1;
        prim = bch_prim_poly(m);
        for (int k = 0; k <= MAX_M; k++) c[k] = 0;
        c[0] = 1;
        j    = i % n;
        done = 1'b0;
        for (int s = 0; s < MAX_M; s++) begin
            if (!done) begin
                root = gf_pow(j, m, prim);
                for (int k = MAX_M; k >= 1; k--) c[k] = c[k-1] ^ gf_mul(c[k], root, m, prim);
                c[0] = gf_mul(c[0], root, m, prim);
                j = (j * 2) % n;
                if (j == (i % n)) done = 1'b1;
            end
        end
        p = '0;
        for (int k = 0; k <= MAX_M; k++) p[k] = ((c[k] & 1) != 0);
        return p;
    endfunction

    function automatic poly_t bch_poly_mul(input poly_t a, input poly_t b);
        poly_t r;
        r = '0;
        for (int k = 0; k < POLY_W; k++) begin
            if (b[k]) r = r ^ (a << k);
        end
        return r;
    endfunction

    function automatic int bch_poly_deg(input poly_t a);
        int d;
        d = -1;
        for (int k = 0; k < POLY_W; k++) begin
            if (a[k]) d = k;
        end
        return d;
    endfunction

    // LCM of the minimal polynomials of alpha^1..alpha^(2T-1). Distinct
    // minimal polynomials are coprime, so the LCM is the product over
    // distinct cosets. If that leaves the degree short of the requested
    // parity width, further consecutive roots are folded in: the result is
    // the narrow-sense BCH code of dimension K, which corrects at least T.
    function automatic poly_t bch_gen_poly(input int m, input int t, input int p);
        int    n;
        int    j;
        bit    done;
        poly_t g;
        poly_t covered;
        n       = (1 << m) - 1;
        g       = POLY_W'(1);
        covered = '0;
        done    = 1'b0;
        for (int i = 1; i < POLY_W; i++) begin
            if (!done && i < n) begin
                if (i > 2 * t - 1 && bch_poly_deg(g) >= p) begin
                    done = 1'b1;
                end else if (!covered[i]) begin
                    g = bch_poly_mul(g, bch_min_poly(i, m));
                    j = i;
                    for (int s = 0; s < MAX_M; s++) begin
                        covered[j] = 1'b1;
                        j = (j * 2) % n;
                    end
                end
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_serial_encode_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bch_serial_encode_if                                         |
// | Description : Bit-serial message input and codeword output handshake.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bch_serial_encode_if;
    logic in_valid;
    logic data_in;
    logic in_ready;
    logic out_valid;
    logic data_out;
    logic out_first;
    logic out_last;

    // Source / sink side driving messages and collecting codewords.
    modport master (
        output in_valid, data_in,
        input  in_ready, out_valid, data_out, out_first, out_last
    );

    // Encoder side.
    modport slave (
        input  in_valid, data_in,
        output in_ready, out_valid, data_out, out_first, out_last
    );
endinterface
`default_nettype wire

// File: rtl/bch_parity_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bch_parity_lfsr                                              |
// | Description : Galois LFSR computing x^P*m(x) mod G one bit per cycle;     |
// |               shift_only drains the remainder MSB-first.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bch_parity_lfsr #(
    parameter int           P = 10,
    parameter logic [P-1:0] G = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         ce,
    input  wire logic         shift_only,
    input  wire logic         din,
    output logic              msb,
    output logic [P-1:0]      state
);

    logic [P-1:0] r_state;
    logic         w_fb;

    // Feedback is suppressed while draining so the register just shifts out.
    assign w_fb = ~shift_only & (din ^ r_state[P-1]);

    // Remainder register: shift, and fold in G when the feedback bit is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= '0;
        end else if (ce) begin
            r_state <= {r_state[P-2:0], 1'b0} ^ (w_fb ? G : '0);
        end
    end

    assign msb   = r_state[P-1];
    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/bch_serial_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bch_serial_encode                                            |
// | Description : Bit-serial systematic BCH encoder: K message bits pass      |
// |               straight through, then N-K parity bits, all MSB-first.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bch_serial_encode
    import bch_serial_encode_pkg::*;
#(
    parameter int N = 15,
    parameter int K = 5,
    parameter int T = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bch_serial_encode_if.slave  stream
);

    localparam int           M       = n2m(N);
    localparam int           P       = N - K;
    localparam poly_t        G_FULL  = bch_gen_poly(M, T, P);
    localparam logic [P-1:0] G       = G_FULL[P-1:0];
    localparam int           CNT_MAX = (K > P) ? K : P;
    localparam int           CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] C_K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] C_P_LAST = CW'(P - 1);

    localparam logic [0:0] S_DATA   = 1'b0;
    localparam logic [0:0] S_PARITY = 1'b1;

    // Refuse to build when the generator degree cannot match the parity width.
    if (M == 0 || bch_poly_deg(G_FULL) != P) begin : g_poly_check
        $error("bch_serial_encode: generator degree %0d does not match N-K=%0d",
               bch_poly_deg(G_FULL), P);
    end

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_data_out;
    logic          r_out_first;
    logic          r_out_last;

    logic          w_xfer;
    logic          w_lfsr_ce;
    logic          w_lfsr_shift_only;
    logic          w_lfsr_msb;
    logic [P-1:0]  w_lfsr_state_unused;
    logic          w_valid_nxt;
    logic          w_data_nxt;
    logic          w_first_nxt;
    logic          w_last_nxt;

    assign w_xfer = stream.in_valid & r_in_ready;

    bch_parity_lfsr #(
        .P (P),
        .G (G)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .ce         (w_lfsr_ce),
        .shift_only (w_lfsr_shift_only),
        .din        (stream.data_in),
        .msb        (w_lfsr_msb),
        .state      (w_lfsr_state_unused)
    );

    // State and bit-position register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_DATA;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state, LFSR control and the next codeword bit with its markers.
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_lfsr_ce         = 1'b0;
        w_lfsr_shift_only = 1'b0;
        w_valid_nxt       = 1'b0;
        w_data_nxt        = 1'b0;
        w_first_nxt       = 1'b0;
        w_last_nxt        = 1'b0;
        case (r_state)
            S_DATA: begin
                if (w_xfer) begin
                    w_lfsr_ce   = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = stream.data_in;
                    w_first_nxt = (r_count == '0);
                    if (r_count == C_K_LAST) begin
                        w_state_nxt = S_PARITY;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: begin
                // Parity drains without stalling; in_valid is ignored here.
                w_lfsr_ce         = 1'b1;
                w_lfsr_shift_only = 1'b1;
                w_valid_nxt       = 1'b1;
                w_data_nxt        = w_lfsr_msb;
                if (r_count == C_P_LAST) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = S_DATA;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
        endcase
    end

    // Registered outputs; in_ready follows the next state so it is low in reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_DATA);
            r_out_valid <= w_valid_nxt;
            r_data_out  <= w_data_nxt;
            r_out_first <= w_first_nxt;
            r_out_last  <= w_last_nxt;
        end
    end

    assign stream.in_ready  = r_in_ready;
    assign stream.out_valid = r_out_valid;
    assign stream.data_out  = r_data_out;
    assign stream.out_first = r_out_first;
    assign stream.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_bch_serial_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bch_serial_encode                                         |
// | Description : Directed self-checking bench for the BCH(15,5) encoder.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bch_serial_encode;

    localparam logic [10:0] C_G_REF = 11'h537;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    bch_serial_encode_if u_if ();

    bch_serial_encode #(
        .N (15),
        .K (5),
        .T (2)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .stream (u_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ready_low = 0;

    bit cap_bit   [$];
    bit cap_first [$];
    bit cap_last  [$];
    int cap_cyc   [$];

    // Cycle stamp for measuring gaps in the output stream.
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every valid codeword bit away from the active edge.
    always @(negedge clk) begin
        if (u_if.out_valid) begin
            cap_bit.push_back(u_if.data_out);
            cap_first.push_back(u_if.out_first);
            cap_last.push_back(u_if.out_last);
            cap_cyc.push_back(cyc);
        end
        if (reset && !u_if.in_ready) ready_low++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference codeword by long division with the known BCH(15,5) generator.
    function automatic logic [14:0] ref_cw(input logic [4:0] msg);
        logic [14:0] r;
        logic [14:0] g;
        r = {msg, 10'b0};
        g = {4'b0, C_G_REF};
        for (int b = 14; b >= 10; b--) begin
            if (r[b]) r = r ^ (g << (b - 10));
        end
        return {msg, r[9:0]};
    endfunction

    function automatic logic [31:0] pack_bits(input int base);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 15; i++) v = {v[30:0], cap_bit[base+i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_first(input int base);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 15; i++) v = {v[30:0], cap_first[base+i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_last(input int base);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 15; i++) v = {v[30:0], cap_last[base+i]};
        return v;
    endfunction

    task automatic clear_cap();
        cap_bit.delete();
        cap_first.delete();
        cap_last.delete();
        cap_cyc.delete();
        ready_low = 0;
    endtask

    task automatic idle();
        u_if.in_valid = 1'b0;
        u_if.data_in  = 1'b0;
    endtask

    task automatic send_bit(input logic b, input string tag);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.data_in  = b;
        while (!ok && t < 40) begin
            @(negedge clk);
            ok = u_if.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check_val({tag, "_accept_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic send_msg(input logic [4:0] msg, input int gap_after, input int gap_len, input string tag);
        for (int i = 0; i < 5; i++) begin
            send_bit(msg[4-i], tag);
            if (i == gap_after) begin
                u_if.in_valid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_bits(input int n, input string tag);
        int t;
        t = 0;
        while (cap_bit.size() < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_count"}, 32'(cap_bit.size()), 32'(n));
    endtask

    task automatic check_cw(input string tag, input int base, input logic [14:0] exp, input int span);
        if (cap_bit.size() < base + 15) begin
            check_val({tag, "_short"}, 32'(cap_bit.size()), 32'(base + 15));
        end else begin
            check_val({tag, "_bits"},  pack_bits(base),  {17'b0, exp});
            check_val({tag, "_first"}, pack_first(base), 32'h4000);
            check_val({tag, "_last"},  pack_last(base),  32'h0001);
            check_val({tag, "_span"},  32'(cap_cyc[base+14] - cap_cyc[base]), 32'(span));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_in_ready"},  32'(u_if.in_ready),  32'd0);
        check_val({tag, "_out_valid"}, 32'(u_if.out_valid), 32'd0);
        check_val({tag, "_data_out"},  32'(u_if.data_out),  32'd0);
        check_val({tag, "_out_first"}, 32'(u_if.out_first), 32'd0);
        check_val({tag, "_out_last"},  32'(u_if.out_last),  32'd0);
    endtask

    initial begin
        int t;
        idle();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero message gives an all-zero codeword, framed by first/last.
        clear_cap();
        send_msg(5'b00000, -1, 0, "zero");
        idle();
        wait_bits(15, "zero");
        check_cw("zero", 0, 15'h0000, 14);

        // Single low-order message bit: x^10 plus its remainder.
        clear_cap();
        send_msg(5'b00001, -1, 0, "m1");
        idle();
        wait_bits(15, "m1");
        check_cw("m1", 0, 15'b000010100110111, 14);
        check_val("m1_ready_low", 32'(ready_low), 32'd10);

        // Three-cycle stall after message bit 2 opens a bubble, same codeword.
        clear_cap();
        send_msg(5'b00001, 2, 3, "gap");
        idle();
        wait_bits(15, "gap");
        check_cw("gap", 0, 15'b000010100110111, 17);
        if (cap_cyc.size() >= 4) check_val("gap_bubble", 32'(cap_cyc[3] - cap_cyc[2]), 32'd4);

        // Back-to-back codewords with no idle cycle between them.
        clear_cap();
        send_msg(5'b00001, -1, 0, "b2b");
        send_msg(5'b10000, -1, 0, "b2b");
        idle();
        wait_bits(30, "b2b");
        check_cw("b2b0", 0,  15'b000010100110111, 14);
        check_cw("b2b1", 15, 15'b100001010011011, 14);
        if (cap_cyc.size() >= 30) check_val("b2b_contig", 32'(cap_cyc[29] - cap_cyc[0]), 32'd29);

        // Every message against the long-division reference.
        for (int m = 0; m < 32; m++) begin
            clear_cap();
            send_msg(5'(m), -1, 0, $sformatf("all%0d", m));
            idle();
            wait_bits(15, $sformatf("all%0d", m));
            if (cap_bit.size() >= 15)
                check_val($sformatf("all%0d_bits", m), pack_bits(0), {17'b0, ref_cw(5'(m))});
        end

        // Reset while codeword bit 8 (parity) is on the output.
        clear_cap();
        send_msg(5'b00001, -1, 0, "mid");
        idle();
        t = 0;
        while (cap_bit.size() < 9 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val("mid_reach_bit8", 32'(cap_bit.size()), 32'd9);
        reset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        clear_cap();
        repeat (5) @(posedge clk);
        #1;
        check_val("midrst_no_stray", 32'(cap_bit.size()), 32'd0);
        send_msg(5'b00001, -1, 0, "post");
        idle();
        wait_bits(15, "post");
        check_cw("post", 0, 15'b000010100110111, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
